// File: rtl/kicker_ctrl_if.sv
`default_nettype none
// ============================================================================
// kicker_ctrl_if : command bundle from the SPI decoder into kicker_ctrl
// Rev 1.0
// ============================================================================
interface kicker_ctrl_if #(
  parameter int STRENGTH_W = 8
);
  logic                  strobe;
  logic [STRENGTH_W-1:0] strength;
  logic                  chan_sel;
  logic                  manual;
  logic                  arm;

  modport master (output strobe, strength, chan_sel, manual, arm);
  modport slave  (input  strobe, strength, chan_sel, manual, arm);
endinterface
`default_nettype wire

// File: rtl/kicker_ctrl.sv
`default_nettype none
// ============================================================================
// kicker_ctrl : kick/chip solenoid controller with lockout and charge timeout.
// Optional ARMED (breakbeam-triggered) mode: define KICKER_BREAKBEAM_EN.
// Rev 1.0
// ============================================================================
module kicker_ctrl #(
  parameter int PRESCALE_DIV   = 576,
  parameter int STRENGTH_W     = 8,
  parameter int LOCKOUT_TICKS  = 5120,
  parameter int CHARGE_TIMEOUT = 65535,
  parameter int CNT_W          = 16
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  kicker_ctrl_if.slave cmd,
  input  wire logic    charge_enable_i,
  input  wire logic    cap_full_i,
  input  wire logic    breakbeam_i,
  output logic         charge_o,
  output logic         fire_kick_o,
  output logic         fire_chip_o,
  output logic         lockout_o,
  output logic         fault_o,
  output logic         busy_o
);

  localparam int                   PW           = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PW-1:0]         c_PRESC_LAST = PW'(PRESCALE_DIV - 1);
  localparam logic [CNT_W-1:0]      c_LOCK_LAST  = CNT_W'(LOCKOUT_TICKS - 1);
  localparam logic [CNT_W-1:0]      c_TIMEOUT    = CNT_W'(CHARGE_TIMEOUT);
  localparam logic [CNT_W-1:0]      c_CNT_MAX    = '1;
  localparam logic [STRENGTH_W-1:0] c_STR_ONE    = STRENGTH_W'(1);

  typedef enum logic [2:0] {
    S_CHARGE  = 3'd0,
    S_FIRE    = 3'd1,
    S_LOCKOUT = 3'd2,
    S_FAULT   = 3'd3,
    S_ARMED   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [CNT_W-1:0]      tmo_q, tmo_d;
  logic [CNT_W-1:0]      lock_q, lock_d;
  logic [STRENGTH_W-1:0] str_q, str_d;
  logic                  chan_q, chan_d;
  logic                  run_q;
  logic                  w_tick;
  logic                  w_charging;
  logic                  w_charge;

`ifdef KICKER_BREAKBEAM_EN
  assign w_charging = (state_q == S_CHARGE) || (state_q == S_ARMED);
`else
  logic w_unused;
  assign w_charging = (state_q == S_CHARGE);
  assign w_unused   = &{1'b0, breakbeam_i, cmd.arm};
`endif

  // run_q holds charge low during reset and for the first cycle after release.
  assign w_tick   = (presc_q == c_PRESC_LAST);
  assign w_charge = run_q & w_charging & charge_enable_i & ~cap_full_i;

  assign charge_o    = w_charge;
  assign fire_kick_o = (state_q == S_FIRE) & ~chan_q;
  assign fire_chip_o = (state_q == S_FIRE) &  chan_q;
  assign lockout_o   = (state_q == S_LOCKOUT);
  assign fault_o     = (state_q == S_FAULT);
  assign busy_o      = (state_q != S_CHARGE);

  always_comb begin
    state_d = state_q;
    presc_d = w_tick ? '0 : presc_q + 1'b1;
    tmo_d   = tmo_q;
    lock_d  = lock_q;
    str_d   = str_q;
    chan_d  = chan_q;

    if (!w_charge)
      tmo_d = '0;
    else if (w_tick && (tmo_q != c_CNT_MAX))
      tmo_d = tmo_q + 1'b1;

    case (state_q)
      S_CHARGE: begin
        if (cmd.strobe && (cmd.strength != '0)) begin
          str_d   = cmd.strength;
          chan_d  = cmd.chan_sel;
          state_d = S_FIRE;
        end else if (cmd.manual) begin
          str_d   = '1;
          chan_d  = 1'b0;
          state_d = S_FIRE;
`ifdef KICKER_BREAKBEAM_EN
        end else if (cmd.arm) begin
          str_d   = cmd.strength;
          chan_d  = cmd.chan_sel;
          state_d = S_ARMED;
`endif
        end else if (tmo_q >= c_TIMEOUT) begin
          state_d = S_FAULT;
        end
      end
      S_FIRE: begin
        if (w_tick) begin
          if (str_q <= c_STR_ONE) begin
            str_d   = '0;
            state_d = S_LOCKOUT;
          end else begin
            str_d = str_q - 1'b1;
          end
        end
      end
      S_LOCKOUT: begin
        // A fresh request restarts the whole lockout window, prescaler included.
        if (cmd.strobe || cmd.manual) begin
          lock_d  = '0;
          presc_d = '0;
        end else if (w_tick) begin
          if (lock_q >= c_LOCK_LAST)
            state_d = S_CHARGE;
          else
            lock_d = lock_q + 1'b1;
        end
      end
      S_FAULT: begin
        if (!charge_enable_i)
          state_d = S_CHARGE;
      end
`ifdef KICKER_BREAKBEAM_EN
      S_ARMED: begin
        if (breakbeam_i)
          state_d = S_FIRE;
        else if (cmd.strobe && (cmd.strength == '0))
          state_d = S_CHARGE;
        else if (tmo_q >= c_TIMEOUT)
          state_d = S_FAULT;
      end
`endif
      default: state_d = S_CHARGE;
    endcase

    if (state_d != state_q) begin
      presc_d = '0;
      tmo_d   = '0;
      lock_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CHARGE;
      presc_q <= '0;
      tmo_q   <= '0;
      lock_q  <= '0;
      str_q   <= '0;
      chan_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tmo_q   <= tmo_d;
      lock_q  <= lock_d;
      str_q   <= str_d;
      chan_q  <= chan_d;
      run_q   <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kicker_ctrl.sv
`default_nettype none
// ============================================================================
// tb_kicker_ctrl : table-driven fire/lockout vectors plus fault, re-strobe,
// reset and (with KICKER_BREAKBEAM_EN) armed-mode sequences. Rev 1.0
// ============================================================================
module tb_kicker_ctrl;
  localparam int DIV = 4;
  localparam int SW  = 8;
  localparam int LT  = 10;
  localparam int TO  = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic charge_enable, cap_full, breakbeam;
  logic charge, fire_kick, fire_chip, lockout, fault, busy;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  kicker_ctrl_if #(.STRENGTH_W(SW)) cmd ();

  kicker_ctrl #(
    .PRESCALE_DIV(DIV), .STRENGTH_W(SW), .LOCKOUT_TICKS(LT),
    .CHARGE_TIMEOUT(TO), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd),
    .charge_enable_i(charge_enable), .cap_full_i(cap_full), .breakbeam_i(breakbeam),
    .charge_o(charge), .fire_kick_o(fire_kick), .fire_chip_o(fire_chip),
    .lockout_o(lockout), .fault_o(fault), .busy_o(busy)
  );

  typedef struct {
    string      name;
    logic       strobe;
    logic       manual;
    logic       chan;
    logic [7:0] str;
    logic       exp_busy;
    int         exp_kick;
    int         exp_chip;
    int         exp_lock;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_range(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic idle_cmd();
    cmd.strobe = 1'b0; cmd.manual = 1'b0; cmd.arm = 1'b0;
    cmd.chan_sel = 1'b0; cmd.strength = '0;
  endtask

  // Pulse one command, then count fire/lockout cycles until back in CHARGE.
  task automatic run_vec(input vec_t v);
    int   k = 0, c = 0, l = 0, n = 0;
    logic first_busy;
    @(negedge clk);
    cmd.strobe = v.strobe; cmd.manual = v.manual;
    cmd.chan_sel = v.chan; cmd.strength = v.str;
    @(negedge clk);
    idle_cmd();
    first_busy = busy;
    while (busy && n < 3000) begin
      if (fire_kick) k++;
      if (fire_chip) c++;
      if (lockout)   l++;
      n++;
      @(negedge clk);
    end
    check({v.name, " busy"}, first_busy, v.exp_busy);
    check({v.name, " done"}, busy, 0);
    check({v.name, " kick"}, k, v.exp_kick);
    check({v.name, " chip"}, c, v.exp_chip);
    check({v.name, " lock"}, l, v.exp_lock);
  endtask

  initial begin
    int n, bad;
    vecs[0] = '{"chip3",  1'b1, 1'b0, 1'b1, 8'd3, 1'b1, 0,    12, 40};
    vecs[1] = '{"zero",   1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 0,    0,  0};
    vecs[2] = '{"strman", 1'b1, 1'b1, 1'b0, 8'd2, 1'b1, 8,    0,  40};
    vecs[3] = '{"kick1",  1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 4,    0,  40};
    vecs[4] = '{"chip5",  1'b1, 1'b0, 1'b1, 8'd5, 1'b1, 0,    20, 40};
    vecs[5] = '{"manual", 1'b0, 1'b1, 1'b1, 8'd7, 1'b1, 1020, 0,  40};

    idle_cmd();
    charge_enable = 1'b1; cap_full = 1'b0; breakbeam = 1'b0;

    // Reset state and charge release.
    repeat (3) @(negedge clk);
    check("rst charge", charge, 0);
    check("rst busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post charge", charge, 1);
    check("post fire", {fire_kick, fire_chip}, 0);
    check("post fault", fault, 0);
    check("post busy", busy, 0);
    check("post lockout", lockout, 0);
    cap_full = 1'b1;
    #1 check("capfull charge", charge, 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Re-strobe during lockout holds it; exit 40 cycles after the last strobe.
    @(negedge clk);
    cmd.strobe = 1'b1; cmd.strength = 8'd1;
    @(negedge clk);
    idle_cmd();
    n = 0;
    while (!lockout && n < 20) begin @(negedge clk); n++; end
    check("rs enter", lockout, 1);
    bad = 0;
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 19; j++) begin
        @(negedge clk);
        if (fire_kick || fire_chip || !lockout) bad++;
      end
      cmd.strobe = 1'b1; cmd.strength = 8'd2;
      @(negedge clk);
      idle_cmd();
    end
    check("rs held", bad, 0);
    n = 0;
    while (lockout && n < 200) begin
      if (fire_kick || fire_chip) bad++;
      n++;
      @(negedge clk);
    end
    check("rs tail", n, 40);
    check("rs nofire", bad, 0);
    check("rs busy", busy, 0);

    // Charge timeout -> FAULT, strobe ignored, cleared by dropping enable.
    cap_full = 1'b0;
    n = 0;
    while (!fault && n < 200) begin @(negedge clk); n++; end
    check_range("tmo cycles", n, 78, 81);
    check("flt fault", fault, 1);
    check("flt charge", charge, 0);
    check("flt busy", busy, 1);
    cmd.strobe = 1'b1; cmd.strength = 8'd3;
    @(negedge clk);
    idle_cmd();
    bad = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (fire_kick || fire_chip || !fault) bad++;
    end
    check("flt ignore", bad, 0);
    charge_enable = 1'b0;
    @(negedge clk);
    check("flt clear", fault, 0);
    check("flt clr busy", busy, 0);
    charge_enable = 1'b1; cap_full = 1'b1;

`ifdef KICKER_BREAKBEAM_EN
    cap_full = 1'b0;
    @(negedge clk);
    cmd.arm = 1'b1; cmd.strength = 8'd5; cmd.chan_sel = 1'b0;
    @(negedge clk);
    idle_cmd();
    check("arm busy", busy, 1);
    check("arm charge", charge, 1);
    check("arm nofire", fire_kick, 0);
    breakbeam = 1'b1;
    @(negedge clk);
    breakbeam = 1'b0;
    cap_full = 1'b1;
    n = 0;
    while (fire_kick && n < 100) begin @(negedge clk); n++; end
    check("bb kick", n, 20);
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    check("bb done", busy, 0);
    cmd.arm = 1'b1; cmd.strength = 8'd4;
    @(negedge clk);
    idle_cmd();
    check("arm2 busy", busy, 1);
    cmd.strobe = 1'b1; cmd.strength = 8'd0;
    @(negedge clk);
    idle_cmd();
    check("disarm", busy, 0);
`else
    cmd.arm = 1'b1; cmd.strength = 8'd5;
    @(negedge clk);
    idle_cmd();
    breakbeam = 1'b1;
    @(negedge clk);
    breakbeam = 1'b0;
    check("arm ignored", busy, 0);
    @(negedge clk);
    check("bb ignored", fire_kick, 0);
`endif

    // Asynchronous reset in the middle of a fire pulse.
    cmd.strobe = 1'b1; cmd.strength = 8'd5;
    @(negedge clk);
    idle_cmd();
    repeat (5) @(negedge clk);
    check("pre rst fire", fire_kick, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst out", {charge, fire_kick, fire_chip, lockout, fault, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after rst busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
